branch_redirect_ctrl: RTL
=========================

Name: branch_redirect_ctrl

Overview:
- Front-end branch controller for the RV32 pipeline.
- Holds a BHT of 2-bit saturating counters that predicts direction at fetch.
- Resolves each branch/jump in EX using the br_taken flag from the branch-condition unit, and on a mispredict sequences the PC redirect and pipeline flush with a valid/ready handshake to fetch.
- Maintains branch/mispredict statistics counters.

Parameters:
- BHT_ENTRIES, 16, number of 2-bit counters; power of 2, min 2.
- PC_W, 32, PC / target width.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_pc  in  PC_W  fetch-stage PC for lookup
- if_pred_taken  out  1  combinational prediction for if_pc
- ex_valid  in  1  EX stage holds a valid instruction
- ex_is_branch  in  1  EX instruction is a conditional branch
- ex_is_jump  in  1  EX instruction is JAL/JALR (always taken)
- ex_pc  in  PC_W  PC of EX instruction
- ex_target  in  PC_W  computed taken target of EX instruction
- ex_pred_taken  in  1  prediction that travelled down with the EX instruction
- br_taken  in  1  branch condition result for EX instruction
- pipe_stall  in  1  pipeline frozen this cycle; EX not advancing
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  PC_W  corrected fetch PC
- redirect_ready  in  1  fetch accepts redirect
- flush  out  1  one-cycle kill of IF/ID/EX-younger instructions
- hold  out  1  request pipeline freeze while redirect pending
- stat_branches  out  32  resolved branch+jump count
- stat_mispredicts  out  32  mispredict count

Behaviour:
- Index idx = pc[log2(BHT_ENTRIES)+1 : 2].
- if_pred_taken = BHT[idx(if_pc)][1], purely combinational.
- Resolve event R = ex_valid & !pipe_stall & state==IDLE & (ex_is_branch | ex_is_jump).
- ex_is_branch and ex_is_jump both high: treat as jump.
- actual = ex_is_jump | br_taken.
- correct_pc = actual ? ex_target : ex_pc + 4, modulo 2^PC_W (wraps).
- mispredict = R & (actual != ex_pred_taken).
- BHT update on R & ex_is_branch & !ex_is_jump: counter +1 if br_taken, −1 otherwise, saturating at 0 and 3. Written on the clock edge; a same-cycle lookup of the same index returns the old value. Jumps never update the BHT.
- Stats: stat_branches +1 on every R; stat_mispredicts +1 on every mispredict. Both saturate at 0xFFFFFFFF.
- FSM states IDLE, REDIRECT:
  - IDLE -> REDIRECT on mispredict. redirect_pc latched at that edge.
  - In REDIRECT: redirect_valid=1, hold=1; redirect_pc stable until accepted.
  - flush=1 only in the first REDIRECT cycle, exactly one cycle even if redirect_ready is low for longer.
  - REDIRECT -> IDLE on redirect_ready=1. Handshake completes that edge.
  - redirect_ready sampled only while redirect_valid=1.
  - EX inputs ignored while in REDIRECT: no R, no BHT or stat update.
- Latency: mispredict resolved in cycle N gives redirect_valid and flush in N+1. Minimum redirect occupancy is 1 cycle (ready already high).
- Correct prediction: no redirect, no flush, no hold.
- Reset (async, any time, including mid-REDIRECT):
  - state=IDLE; redirect_valid=0, flush=0, hold=0, redirect_pc=0.
  - Every BHT entry = 2'b01 (weakly not-taken); both stats=0.
  - A pending redirect is dropped.

Test Plan:
- Reset then if_pc=0x100 -> if_pred_taken=0; stats 0; redirect_valid=0.
- Branch ex_pc=0x100, target 0x80, br_taken=1, ex_pred_taken=0, redirect_ready=1 -> next cycle redirect_valid=1, redirect_pc=0x80, flush=1 for 1 cycle, back to IDLE. stat_mispredicts=1, BHT[0]=2, and if_pred_taken for 0x100 reads 1 from that cycle.
- Same branch resolved 3 more times taken with matching predictions -> no redirect; BHT[0] saturates at 3. One not-taken with pred=1 -> redirect_pc=0x104; BHT[0]=2.
- Mispredict with redirect_ready low 4 cycles -> redirect_valid and hold high 4 cycles, flush only the first, redirect_pc stable. A concurrent valid EX branch during those cycles leaves stats unchanged.
- JAL ex_pc=0x200, target 0x400, ex_pred_taken=0 -> redirect to 0x400, BHT unchanged, stat_branches +1. Branch at pc 0xFFFFFFFC not-taken with pred taken -> redirect_pc=0x0.
- rst_n low mid-REDIRECT -> outputs clear immediately, BHT reads 2'b01; pipe_stall=1 during a branch -> no resolution until stall drops.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: front-end branch controller for the RV32 pipeline.
// Predicts direction at fetch from a BHT of 2-bit saturating counters,
// resolves branches/jumps in EX, and on a mispredict drives a PC redirect
// to fetch (valid/ready) together with a one-cycle flush and a hold.
// Ports:
//   clk, rst_n                   clock, async active-low reset
//   if_pc / if_pred_taken        fetch lookup, combinational prediction
//   ex_*, br_taken, pipe_stall   EX-stage resolution inputs
//   redirect_valid/_pc/_ready    redirect handshake to fetch
//   flush, hold                  pipeline kill pulse / freeze request
//   stat_branches/mispredicts    saturating statistics counters
module branch_redirect_ctrl #(
    parameter int unsigned BHT_ENTRIES = 16,
    parameter int unsigned PC_W        = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [PC_W-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_is_jump,
    input  logic [PC_W-1:0] ex_pc,
    input  logic [PC_W-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic            br_taken,
    input  logic            pipe_stall,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    input  logic            redirect_ready,
    output logic            flush,
    output logic            hold,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispredicts
);

    localparam int unsigned IDX_W  = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;
    localparam int unsigned STAT_W = 32;

    typedef enum logic [0:0] {S_IDLE, S_REDIRECT} state_e;

    state_e              state_q, state_d;
    logic [1:0]          bht_q [BHT_ENTRIES];
    logic [PC_W-1:0]     redirect_pc_q;
    logic                flush_q;
    logic [STAT_W-1:0]   stat_br_q, stat_mis_q;

    logic [IDX_W-1:0]    if_idx, ex_idx;
    logic                resolve, actual, mispredict, bht_upd;
    logic [PC_W-1:0]     correct_pc;
    logic                unused_pc_bits;

    // PC bits outside the word-aligned index do not take part in prediction
    assign unused_pc_bits = ^{if_pc[1:0], if_pc[PC_W-1:IDX_W+2]};

    assign if_idx        = if_pc[IDX_W+1:2];
    assign ex_idx        = ex_pc[IDX_W+1:2];
    assign if_pred_taken = bht_q[if_idx][1];

    // Resolution is only accepted while no redirect is outstanding
    assign resolve    = ex_valid & ~pipe_stall & (state_q == S_IDLE)
                      & (ex_is_branch | ex_is_jump);
    assign actual     = ex_is_jump | br_taken;
    assign correct_pc = actual ? ex_target : ex_pc + PC_W'(4);
    assign mispredict = resolve & (actual != ex_pred_taken);
    // A branch+jump encoding is a jump, so it never trains the BHT
    assign bht_upd    = resolve & ex_is_branch & ~ex_is_jump;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (mispredict)     state_d = S_REDIRECT;
            S_REDIRECT: if (redirect_ready) state_d = S_IDLE;
            default:                        state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        redirect_valid = 1'b0;
        hold           = 1'b0;
        if (state_q == S_REDIRECT) begin
            redirect_valid = 1'b1;
            hold           = 1'b1;
        end
    end

    assign redirect_pc      = redirect_pc_q;
    assign flush            = flush_q;
    assign stat_branches    = stat_br_q;
    assign stat_mispredicts = stat_mis_q;

    // Redirect target capture and single-cycle flush pulse on REDIRECT entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            redirect_pc_q <= '0;
            flush_q       <= 1'b0;
        end else begin
            flush_q <= mispredict;
            if (mispredict) begin
                redirect_pc_q <= correct_pc;
            end
        end
    end

    // BHT training with saturating 2-bit counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= 2'b01;
            end
        end else if (bht_upd) begin
            if (br_taken) begin
                if (bht_q[ex_idx] != 2'b11) bht_q[ex_idx] <= bht_q[ex_idx] + 2'b01;
            end else begin
                if (bht_q[ex_idx] != 2'b00) bht_q[ex_idx] <= bht_q[ex_idx] - 2'b01;
            end
        end
    end

    // Saturating statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            if (resolve && (stat_br_q != '1))     stat_br_q  <= stat_br_q + STAT_W'(1);
            if (mispredict && (stat_mis_q != '1)) stat_mis_q <= stat_mis_q + STAT_W'(1);
        end
    end

endmodule
